yarvi_fetch_queue: RTL and testbench

//  Decoupled fetch front end that sits between code memory and DE/RF; it replaces the lock-step FE stage.
//  - Prefetches sequential instructions into a DEPTH-entry FIFO.
//  - Delivers them to decode over a valid/ready handshake.
//  - On restart, flushes the FIFO and discards any in-flight fetch.

---
 rtl/yarvi_fetch_queue.sv | 114 +++++++++++
 tb/tb_yarvi_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_fetch_queue.sv
// yarvi_fetch_queue: decoupled fetch front end that prefetches sequential words into a DEPTH-entry FIFO for decode.
// Define YARVI_FQ_BYPASS_EN to let a response reach decode in its arrival cycle when the FIFO is empty.
module yarvi_fetch_queue #(
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [PC_W-1:0]        restart_pc,
  output logic                   code_req,
  output logic [PC_W-3:0]        code_address,
  input  logic [31:0]            code_rdata,
  output logic                   fq_valid,
  output logic [PC_W-1:0]        fq_pc,
  output logic [31:0]            fq_insn,
  input  logic                   fq_ready,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~{{(PC_W-2){1'b0}}, 2'b11};
  endfunction

  function automatic logic [PC_W-1:0] next_word_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

  logic [PC_W-1:0]  pc_p0;
  logic [PC_W-1:0]  issue_pc_p0;
  logic             vld_p1;
  logic [PC_W-1:0]  pc_p1;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [31:0]      insn_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;

  logic             bypass_hit;
  logic             fire;
  logic             fifo_deq;
  logic             enq;

  // Stage p0: issue. A slot is reserved for every request, so a response always finds room.
  assign occupancy    = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign code_req     = !reset && (restart || (occupancy < DEPTH_C));
  assign issue_pc_p0  = restart ? word_align(restart_pc) : pc_p0;
  assign code_address = issue_pc_p0[PC_W-1:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
    end else begin
      vld_p1 <= code_req;
      if (code_req) begin
        pc_p0 <= next_word_pc(issue_pc_p0);
        pc_p1 <= issue_pc_p0;
      end
    end
  end

  // Stage p1: response arrives with code_rdata; it bypasses, enqueues, or is dropped by a restart.
`ifdef YARVI_FQ_BYPASS_EN
  assign bypass_hit = vld_p1 && (count == '0);
  assign fq_pc      = bypass_hit ? pc_p1 : pc_mem[head];
  assign fq_insn    = bypass_hit ? code_rdata : insn_mem[head];
`else
  assign bypass_hit = 1'b0;
  assign fq_pc      = pc_mem[head];
  assign fq_insn    = insn_mem[head];
`endif

  assign fq_valid = !reset && !restart && ((count != '0) || bypass_hit);
  assign fire     = fq_valid && fq_ready;
  assign fifo_deq = fire && !bypass_hit;
  assign enq      = vld_p1 && !restart && !(bypass_hit && fq_ready);
  assign fq_count = count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        insn_mem[i] <= '0;
      end
    end else if (restart) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        pc_mem[tail]   <= pc_p1;
        insn_mem[tail] <= code_rdata;
        tail           <= tail + PTR_W'(1);
      end
      if (fifo_deq) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(fifo_deq);
    end
  end

endmodule

// File: tb/tb_yarvi_fetch_queue.sv
// Randomized bench for yarvi_fetch_queue against a queue-level model of fetch, delivery and restart.
module tb_yarvi_fetch_queue;

  localparam int          PC_W     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic [31:0] restart_pc = '0;
  logic        code_req;
  logic [29:0] code_address;
  logic [31:0] code_rdata = '0;
  logic        fq_valid;
  logic [31:0] fq_pc;
  logic [31:0] fq_insn;
  logic        fq_ready = 1'b0;
  logic [2:0]  fq_count;

  yarvi_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .restart(restart), .restart_pc(restart_pc),
    .code_req(code_req), .code_address(code_address), .code_rdata(code_rdata),
    .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_insn(fq_insn), .fq_ready(fq_ready),
    .fq_count(fq_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Code memory: always accepts, answers one cycle later.
  always @(posedge clock) code_rdata <= mem_word(code_address);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t      q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;
  logic [31:0] exp_next;
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_infl    = 1'b0;
    m_infl_pc = '0;
    m_pc      = RESET_PC;
    exp_next  = RESET_PC;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_code_req"}, 64'(code_req), 64'd0);
    check_val({tag, "_fq_valid"}, 64'(fq_valid), 64'd0);
    check_val({tag, "_fq_count"}, 64'(fq_count), 64'd0);
    check_val({tag, "_fq_pc"},    64'(fq_pc),    64'd0);
    check_val({tag, "_fq_insn"},  64'(fq_insn),  64'd0);
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model across the rising edge.
  task automatic cycle(input bit rs, input logic [31:0] rpc, input bit rdy);
    bit          e_req;
    bit          e_valid;
    bit          byp;
    logic [31:0] issued;
    entry_t      hd;
    @(negedge clock);
    restart    = rs;
    restart_pc = rpc;
    fq_ready   = rdy;
    #1;
    e_req  = rs || ((q.size() + int'(m_infl)) < DEPTH);
    issued = rs ? {rpc[31:2], 2'b00} : m_pc;
    byp    = 1'b0;
`ifdef YARVI_FQ_BYPASS_EN
    byp = (q.size() == 0) && m_infl;
`endif
    e_valid = !rs && ((q.size() != 0) || byp);
    check_val("code_req", 64'(code_req), 64'(e_req));
    if (e_req) check_val("code_address", 64'(code_address), 64'(issued[31:2]));
    check_val("fq_valid", 64'(fq_valid), 64'(e_valid));
    check_val("fq_count", 64'(fq_count), 64'(q.size()));
    if (e_valid) begin
      if (byp) begin
        hd.pc   = m_infl_pc;
        hd.insn = mem_word(m_infl_pc[31:2]);
      end else begin
        hd = q[0];
      end
      check_val("fq_pc", 64'(fq_pc), 64'(hd.pc));
      check_val("fq_insn", 64'(fq_insn), 64'(hd.insn));
      if (rdy) begin
        check_val("order", 64'(fq_pc), 64'(exp_next));
        exp_next = exp_next + 32'd4;
      end
    end
    if (rs) begin
      q.delete();
      exp_next = issued;
    end else begin
      if (e_valid && rdy && !byp) void'(q.pop_front());
      if (m_infl && !(byp && rdy)) q.push_back({m_infl_pc, mem_word(m_infl_pc[31:2])});
    end
    m_infl = e_req;
    if (e_req) begin
      m_infl_pc = issued;
      m_pc      = issued + 32'd4;
    end
  endtask

  // Reset raised partway through a cycle, held with restart toggling, released just after a rising edge.
  task automatic apply_reset(input int hold);
    @(negedge clock);
    #3;
    reset    = 1'b1;
    restart  = 1'b1;
    fq_ready = 1'b1;
    #1;
    check_idle("rst_async");
    repeat (hold) begin
      @(negedge clock);
      restart = 1'($urandom_range(0, 1));
      #1;
      check_idle("rst_hold");
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    restart = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    restart = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_idle("rst_init");
    @(posedge clock);
    #1;
    reset   = 1'b0;
    restart = 1'b0;

    // Streaming with decode always ready.
    repeat (20) cycle(1'b0, '0, 1'b1);

    // Back-pressure from reset: credit stops fetching at DEPTH, then drains in order.
    apply_reset(2);
    repeat (10) cycle(1'b0, '0, 1'b0);
    repeat (12) cycle(1'b0, '0, 1'b1);

    // Partially filled queue with a fetch in flight, then redirect.
    cycle(1'b1, 32'h0000_0040, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);

    // Redirect to the top of the address space and wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF3, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1);

    // Queue holding entries, then asynchronous reset.
    repeat (2) cycle(1'b0, '0, 1'b0);
    apply_reset(1);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // Randomized traffic with varying back-pressure and occasional redirects and resets.
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = 20 + blk * 15;
      for (int n = 0; n < 400; n++) begin
        bit          rs;
        logic [31:0] rpc;
        rs  = ($urandom_range(0, 15) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
        cycle(rs, rpc, $urandom_range(0, 99) < rdy_pct);
      end
      apply_reset($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
